// File: rtl/keccak_stream_padder.sv
// Streaming Keccak multi-rate padder: packs 64-bit words into rate blocks
// and appends domain byte / 0x80 terminator, one full-width block per handshake.
module keccak_stream_padder #(
    parameter int         RATE0_WORDS = 21,
    parameter int         RATE1_WORDS = 17,
    parameter logic [7:0] DS0         = 8'h1F,
    parameter logic [7:0] DS1         = 8'h06
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       rate_sel,
    input  logic                       ds_sel,
    input  logic [63:0]                in,
    input  logic [3:0]                 in_bytes,
    input  logic                       in_last,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [64*RATE0_WORDS-1:0]  out,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int NB = 8 * RATE0_WORDS;
    localparam int PW = (RATE0_WORDS > 1) ? $clog2(RATE0_WORDS) : 1;
    localparam int EW = $clog2(NB + 1);

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        PAD,
        OUT,
        PADONLY
    } state_t;

    state_t                    state_q;
    state_t                    next_q;
    logic [PW-1:0]             p_q;
    logic [PW-1:0]             rm1_q;
    logic [7:0]                ds_q;
    logic [EW-1:0]             end_q;
    logic [64*RATE0_WORDS-1:0] buf_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic                      out_last_q;

    logic [64*RATE0_WORDS-1:0] pad_d;
    logic [EW-1:0]             end_d;
    logic [EW-1:0]             pos_d;
    logic [EW-1:0]             lastb_d;
    logic                      full_d;

    assign end_d   = EW'({p_q, 3'b000}) + EW'(in_bytes);
    assign lastb_d = EW'({rm1_q, 3'b111});
    assign full_d  = (p_q == rm1_q) && (in_bytes == 4'd8);
    // A pad-only block is the same operation with the data ending at byte 0.
    assign pos_d   = (state_q == PADONLY) ? '0 : end_q;

    always_comb begin
        pad_d = buf_q;
        for (int k = 0; k < NB; k++) begin
            if (EW'(k) >= pos_d) begin
                pad_d[8*k +: 8] = 8'h00;
            end
            if (EW'(k) == pos_d) begin
                pad_d[8*k +: 8] = ds_q;
            end
            if (EW'(k) == lastb_d) begin
                pad_d[8*k +: 8] = pad_d[8*k +: 8] | 8'h80;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            next_q      <= IDLE;
            p_q         <= '0;
            rm1_q       <= '0;
            ds_q        <= '0;
            end_q       <= '0;
            buf_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        rm1_q      <= rate_sel ? PW'(RATE1_WORDS - 1)
                                               : PW'(RATE0_WORDS - 1);
                        ds_q       <= ds_sel ? DS1 : DS0;
                        buf_q      <= '0;
                        p_q        <= '0;
                        in_ready_q <= 1'b1;
                        state_q    <= ABSORB;
                    end
                end
                ABSORB: begin
                    if (in_valid) begin
                        buf_q[{p_q, 6'b000000} +: 64] <= in;
                        if (in_last) begin
                            end_q      <= end_d;
                            in_ready_q <= 1'b0;
                            if (full_d) begin
                                out_valid_q <= 1'b1;
                                out_last_q  <= 1'b0;
                                next_q      <= PADONLY;
                                state_q     <= OUT;
                            end else begin
                                state_q <= PAD;
                            end
                        end else if (p_q == rm1_q) begin
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= 1'b0;
                            next_q      <= ABSORB;
                            state_q     <= OUT;
                        end else begin
                            p_q <= p_q + 1'b1;
                        end
                    end
                end
                PAD, PADONLY: begin
                    buf_q       <= pad_d;
                    out_valid_q <= 1'b1;
                    out_last_q  <= 1'b1;
                    next_q      <= IDLE;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        buf_q       <= '0;
                        p_q         <= '0;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        in_ready_q  <= (next_q == ABSORB);
                        state_q     <= next_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out       = buf_q;

endmodule

// File: doc/keccak_stream_padder.md
# keccak_stream_padder

Sequential, parametrised successor to the combinational word padder: accepts a message as a stream of 64-bit little-endian words over a valid/ready handshake, packs them into rate-sized blocks, and applies Keccak multi-rate padding. Padding is the domain-separation byte followed by zero fill, with 0x80 OR-ed into the last rate byte. Sits between the ML-DSA message/seed sources and the Keccak-f[1600] permutation. It emits one full-width block per handshake, with per-message selection of rate (SHAKE-128 / SHAKE-256) and domain byte (SHAKE 0x1F / SHA3 0x06).

## Interface
- RATE0_WORDS, 21: rate in 64-bit words when rate_sel=0 (SHAKE-128, 168 B); also sets out width.
- RATE1_WORDS, 17: rate in 64-bit words when rate_sel=1 (SHAKE-256, 136 B); must be ≤ RATE0_WORDS.
- DS0, 8'h1F: domain byte when ds_sel=0 (SHAKE).
- DS1, 8'h06: domain byte when ds_sel=1 (SHA3).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin message; sampled only in IDLE.
- rate_sel  in  1  latched at start.
- ds_sel  in  1  latched at start.
- in  in  64  message word; byte k at bits [8k+7:8k].
- in_bytes  in  4  valid bytes in the last word, 0..8; ignored unless in_last.
- in_last  in  1  marks the final word of the message.
- in_valid  in  1  word present.
- in_ready  out  1  word accepted when in_valid & in_ready.
- out  out  64*RATE0_WORDS  block; word i at bits [64i+63:64i]; words ≥ active rate always zero.
- out_last  out  1  block is the final (padded) block.
- out_valid  out  1  block present.
- out_ready  in  1  block consumed when out_valid & out_ready.

## Operation
- States: IDLE, ABSORB, PAD, OUT, PADONLY.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start, latch R (RATE0/1_WORDS) and DS; clear buffer and word pointer p; go to ABSORB.
- ABSORB:
  - in_ready=1. Each accepted word is written to buffer[p].
  - Not last, p<R-1: p++.
  - Not last, p==R-1: go to OUT with out_last=0 and next=ABSORB.
  - Last: end_pos = 8p+in_bytes.
    - If end_pos==8R (block full of data): OUT with out_last=0 and next=PADONLY.
    - Else go to PAD.
- PAD (exactly 1 cycle), applied to the buffer:
  - Bytes at index ≥ end_pos cleared.
  - Byte end_pos = DS.
  - Byte 8R-1 |= 0x80. When end_pos==8R-1 the byte is DS|0x80.
  - Then OUT with out_last=1 and next=IDLE.
- PADONLY (1 cycle):
  - Buffer cleared.
  - Byte 0 = DS; byte 8R-1 |= 0x80.
  - OUT with out_last=1 and next=IDLE.
- OUT:
  - out_valid=1; out and out_last held stable until out_ready.
  - On handshake: clear buffer, p=0, go to next.
- in_bytes=0 with in_last is legal: empty message, or a message ending on a word boundary. in_bytes>8 is illegal.
- start outside IDLE is ignored. rate_sel/ds_sel changes mid-message have no effect.
- Reset (any state): all state lost.
  - State=IDLE, p=0, buffer=0.
  - out=0, out_valid=0, out_last=0, in_ready=0.

## Timing
- start at edge T → ABSORB, in_ready=1 from T+1.
- Non-final full block: last word accepted at edge T → out_valid=1 from T+1.
- Final word accepted at T → PAD at T+1 → out_valid=1 at T+2.
- Extra pad-only block: handshake of the data block at T → PADONLY at T+1 → out_valid at T+2.
- out_valid & out_ready at T → out_valid=0 at T+1. in_ready=1 at T+1 if returning to ABSORB.
- in_ready=0 in PAD, OUT, PADONLY, IDLE: no input accepted while a block is pending.
- Throughput: R+1 cycles per non-final block with out_ready held high.

## Test plan
- Empty SHAKE-128 (rate_sel=0, ds_sel=0; in_last, in_bytes=0):
  - one block, out_last=1.
  - byte0=0x1F, byte167=0x80, all other bits zero.
  - out_valid exactly 2 cycles after the input handshake.
- SHAKE-256, 3 bytes (in=64'h0000000000CCBBAA, in_bytes=3, last):
  - word0=64'h000000001FCCBBAA, word16=64'h8000000000000000.
  - bits ≥1088 zero.
- SHAKE-256, 135 bytes (16 full words, then in_bytes=7):
  - byte135=0x9F with ds_sel=0.
  - byte135=0x86 with ds_sel=1.
  - single block, out_last=1.
- SHAKE-256, exactly 136 bytes (17th word in_bytes=8, last):
  - block 1: data, out_last=0.
  - block 2: byte0=0x1F, byte135=0x80, rest zero, out_last=1.
- SHAKE-128, 200-byte message with out_ready held low 10 cycles per block:
  - out stable and in_ready=0 while stalled.
  - block 1 full data, out_last=0.
  - block 2 carries bytes 168..199, byte32=0x1F, byte167=0x80, out_last=1.
- Reset asserted mid-ABSORB (after 5 words):
  - outputs zero immediately.
  - next start plus an empty message yields the empty-message block exactly, with no residue from earlier words.
